// File: rtl/fetch_issue_tracked.sv
// Fetch PC generator with a valid/ready request channel and an in-order tracking FIFO.
// Redirects kill every outstanding fetch, so stale responses never issue.
module fetch_issue_tracked #(
  parameter int          CORE         = 0,
  parameter              RESET_PC     = 0,
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned INST_BYTES   = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [1:0]                        next_PC_select,
  input  logic [ADDRESS_BITS-1:0]           target_PC,
  input  logic [ADDRESS_BITS-1:0]           trap_PC,
  output logic                              i_mem_req_valid,
  input  logic                              i_mem_req_ready,
  output logic [ADDRESS_BITS-1:0]           i_mem_read_address,
  input  logic                              i_mem_resp_valid,
  output logic                              issue_valid,
  output logic [ADDRESS_BITS-1:0]           issue_PC,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight_count,
  output logic                              protocol_error
);

  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] SEL_INC    = 2'b00;
  localparam logic [1:0] SEL_STALL  = 2'b01;
  localparam logic [1:0] SEL_TARGET = 2'b10;
  localparam logic [1:0] SEL_TRAP   = 2'b11;

  localparam logic [ADDRESS_BITS-1:0] PC_INC     = ADDRESS_BITS'(INST_BYTES);
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(INST_BYTES - 1);

  logic [ADDRESS_BITS-1:0] r_pc;
  logic [ADDRESS_BITS-1:0] r_fifo_pc [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] r_fifo_killed;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;
  logic                    r_issue_valid;
  logic [ADDRESS_BITS-1:0] r_issue_pc;
  logic                    r_protocol_error;

  logic w_redirect;
  logic w_req_valid;
  logic w_push;
  logic w_pop;
  logic w_empty;

  always_comb begin
    w_redirect  = next_PC_select[1];
    w_empty     = (r_count == '0);
    w_req_valid = !reset && (next_PC_select == SEL_INC) && (r_count < CNT_W'(MAX_INFLIGHT));
    w_push      = w_req_valid && i_mem_req_ready;
    w_pop       = i_mem_resp_valid && !w_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc             <= ADDRESS_BITS'(RESET_PC);
      r_fifo_killed    <= '0;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_issue_valid    <= 1'b0;
      r_issue_pc       <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      unique case (next_PC_select)
        SEL_INC:    if (w_push) r_pc <= r_pc + PC_INC;
        SEL_STALL:  r_pc <= r_pc;
        SEL_TARGET: r_pc <= target_PC & ALIGN_MASK;
        SEL_TRAP:   r_pc <= trap_PC & ALIGN_MASK;
        default:    r_pc <= r_pc;
      endcase

      // Push and redirect are mutually exclusive, so the blanket kill never races a fresh entry.
      if (w_push) begin
        r_fifo_pc[r_tail]     <= r_pc;
        r_fifo_killed[r_tail] <= 1'b0;
        r_tail                <= r_tail + PTR_W'(1);
      end
      if (w_redirect) r_fifo_killed <= '1;

      if (w_pop) r_head <= r_head + PTR_W'(1);

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_issue_valid <= w_pop && !r_fifo_killed[r_head] && !w_redirect;
      if (w_pop) r_issue_pc <= r_fifo_pc[r_head];

      if (i_mem_resp_valid && w_empty) r_protocol_error <= 1'b1;
    end
  end

  assign i_mem_req_valid    = w_req_valid;
  assign i_mem_read_address = r_pc;
  assign issue_valid        = r_issue_valid;
  assign issue_PC           = r_issue_pc;
  assign inflight_count     = r_count;
  assign protocol_error     = r_protocol_error;

endmodule

// File: tb/tb_fetch_issue_tracked.sv
// Directed bench for fetch_issue_tracked: streaming, full FIFO, redirect kill,
// protocol error, PC wrap and mid-stream reset, all with hand-computed expectations.
module tb_fetch_issue_tracked;

  logic        clock;
  logic        reset;
  logic [1:0]  next_PC_select;
  logic [31:0] target_PC;
  logic [31:0] trap_PC;
  logic        i_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] i_mem_read_address;
  logic        i_mem_resp_valid;
  logic        issue_valid;
  logic [31:0] issue_PC;
  logic [2:0]  inflight_count;
  logic        protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_issue_tracked #(
    .CORE         (0),
    .RESET_PC     (32'h100),
    .ADDRESS_BITS (32),
    .INST_BYTES   (4),
    .MAX_INFLIGHT (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .next_PC_select     (next_PC_select),
    .target_PC          (target_PC),
    .trap_PC            (trap_PC),
    .i_mem_req_valid    (i_mem_req_valid),
    .i_mem_req_ready    (i_mem_req_ready),
    .i_mem_read_address (i_mem_read_address),
    .i_mem_resp_valid   (i_mem_resp_valid),
    .issue_valid        (issue_valid),
    .issue_PC           (issue_PC),
    .inflight_count     (inflight_count),
    .protocol_error     (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    next_PC_select   = 2'b01;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    next_PC_select   = 2'b00;
    i_mem_req_ready  = 1'b1;
    i_mem_resp_valid = 1'b0;
    target_PC        = '0;
    trap_PC          = '0;

    // Reset state; request must be gated by reset even with select=00, ready=1.
    tick();
    tick();
    check_eq("rst_req_valid", i_mem_req_valid, 0);
    check_eq("rst_addr", i_mem_read_address, 32'h100);
    check_eq("rst_count", inflight_count, 0);
    check_eq("rst_issue_valid", issue_valid, 0);
    check_eq("rst_issue_pc", issue_PC, 0);
    check_eq("rst_perr", protocol_error, 0);
    reset = 1'b0;
    settle();

    // Streaming: one request per cycle, response one cycle later.
    check_eq("st_req_valid0", i_mem_req_valid, 1);
    check_eq("st_addr0", i_mem_read_address, 32'h100);
    tick();
    check_eq("st_count0", inflight_count, 1);
    i_mem_resp_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      check_eq("st_addr", i_mem_read_address, 32'h100 + 32'(4 * k));
      check_eq("st_req_valid", i_mem_req_valid, 1);
      tick();
      check_eq("st_issue_valid", issue_valid, 1);
      check_eq("st_issue_pc", issue_PC, 32'h100 + 32'(4 * (k - 1)));
      check_eq("st_count", inflight_count, 1);
    end
    next_PC_select = 2'b01;
    tick();
    check_eq("st_drain_pc", issue_PC, 32'h110);
    check_eq("st_drain_valid", issue_valid, 1);
    check_eq("st_drain_count", inflight_count, 0);
    i_mem_resp_valid = 1'b0;
    tick();
    check_eq("st_idle_valid", issue_valid, 0);
    check_eq("st_idle_pc_hold", issue_PC, 32'h110);

    // Ready low holds PC; then fill to MAX_INFLIGHT.
    do_reset();
    next_PC_select = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("nr_addr", i_mem_read_address, 32'h100);
      check_eq("nr_count", inflight_count, 0);
    end
    i_mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_eq("full_count", inflight_count, 4);
    check_eq("full_req_valid", i_mem_req_valid, 0);
    check_eq("full_addr", i_mem_read_address, 32'h110);
    i_mem_resp_valid = 1'b1;
    settle();
    check_eq("full_pop_cycle_req", i_mem_req_valid, 0);
    tick();
    i_mem_resp_valid = 1'b0;
    settle();
    check_eq("full_after_pop_count", inflight_count, 3);
    check_eq("full_after_pop_req", i_mem_req_valid, 1);
    check_eq("full_issue_pc", issue_PC, 32'h100);
    check_eq("full_issue_valid", issue_valid, 1);
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("full_drain_pc", issue_PC, 32'h100 + 32'(4 * k));
    end
    i_mem_resp_valid = 1'b0;
    tick();
    check_eq("full_drain_count", inflight_count, 0);

    // Redirect to target kills three outstanding fetches.
    do_reset();
    next_PC_select  = 2'b00;
    i_mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check_eq("rd_count", inflight_count, 3);
    next_PC_select = 2'b10;
    target_PC      = 32'h203;
    settle();
    check_eq("rd_req_blocked", i_mem_req_valid, 0);
    tick();
    check_eq("rd_addr", i_mem_read_address, 32'h200);
    check_eq("rd_count_hold", inflight_count, 3);
    next_PC_select   = 2'b01;
    i_mem_resp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rd_killed_valid", issue_valid, 0);
      check_eq("rd_killed_pc", issue_PC, 32'h100 + 32'(4 * k));
    end
    i_mem_resp_valid = 1'b0;
    next_PC_select   = 2'b00;
    settle();
    check_eq("rd_new_addr", i_mem_read_address, 32'h200);
    tick();
    next_PC_select   = 2'b01;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b1;
    tick();
    check_eq("rd_new_valid", issue_valid, 1);
    check_eq("rd_new_pc", issue_PC, 32'h200);
    i_mem_resp_valid = 1'b0;

    // Trap redirect coinciding with a pop.
    do_reset();
    next_PC_select  = 2'b00;
    i_mem_req_ready = 1'b1;
    tick();
    tick();
    next_PC_select   = 2'b11;
    trap_PC          = 32'h80;
    i_mem_resp_valid = 1'b1;
    tick();
    check_eq("tp_pop_valid", issue_valid, 0);
    check_eq("tp_pop_pc", issue_PC, 32'h100);
    check_eq("tp_addr", i_mem_read_address, 32'h80);
    check_eq("tp_count", inflight_count, 1);
    next_PC_select = 2'b01;
    tick();
    check_eq("tp_rest_valid", issue_valid, 0);
    check_eq("tp_rest_count", inflight_count, 0);
    i_mem_resp_valid = 1'b0;
    next_PC_select   = 2'b00;
    settle();
    check_eq("tp_resume_req", i_mem_req_valid, 1);
    tick();
    next_PC_select   = 2'b01;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b1;
    tick();
    check_eq("tp_resume_valid", issue_valid, 1);
    check_eq("tp_resume_pc", issue_PC, 32'h80);

    // Response with empty FIFO: sticky error, count stays 0.
    tick();
    i_mem_resp_valid = 1'b0;
    check_eq("pe_set", protocol_error, 1);
    check_eq("pe_count", inflight_count, 0);
    check_eq("pe_issue_valid", issue_valid, 0);
    tick();
    tick();
    check_eq("pe_sticky", protocol_error, 1);

    // Empty-FIFO response with a same-cycle push still flags the error.
    do_reset();
    check_eq("pe_rst_clear", protocol_error, 0);
    next_PC_select   = 2'b00;
    i_mem_req_ready  = 1'b1;
    i_mem_resp_valid = 1'b1;
    tick();
    i_mem_resp_valid = 1'b0;
    check_eq("pe_push_err", protocol_error, 1);
    check_eq("pe_push_count", inflight_count, 1);
    check_eq("pe_push_valid", issue_valid, 0);

    // PC wrap, then reset with two fetches outstanding.
    do_reset();
    next_PC_select = 2'b10;
    target_PC      = 32'hFFFF_FFFE;
    tick();
    check_eq("wr_addr", i_mem_read_address, 32'hFFFF_FFFC);
    next_PC_select  = 2'b00;
    i_mem_req_ready = 1'b1;
    tick();
    check_eq("wr_wrap", i_mem_read_address, 32'h0);
    tick();
    check_eq("wr_count", inflight_count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    next_PC_select = 2'b01;
    check_eq("mr_count", inflight_count, 0);
    check_eq("mr_addr", i_mem_read_address, 32'h100);
    check_eq("mr_issue_valid", issue_valid, 0);
    i_mem_resp_valid = 1'b1;
    tick();
    i_mem_resp_valid = 1'b0;
    check_eq("mr_stale_resp_err", protocol_error, 1);
    check_eq("mr_stale_count", inflight_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
